// File: rtl/bnn_acc_array_if.sv
// Handshake and data bundle for the binarized-neuron accumulator.
// master = producer/consumer side (buffers), slave = accumulator.
interface bnn_acc_array_if #(
  parameter int ACC_WIDTH = 12,
  parameter int LANES     = 4,
  parameter int LEN_WIDTH = 8
);
  logic                 start;
  logic [LEN_WIDTH-1:0] vec_len;
  logic [ACC_WIDTH-1:0] bias;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES-1:0]     x_bits;
  logic [LANES-1:0]     w_bits;
  logic [LANES-1:0]     lane_mask;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 act_out;
  logic                 sat_flag;
  logic                 busy;

  modport master (
    output start, vec_len, bias, in_valid, x_bits, w_bits, lane_mask, out_ready,
    input  in_ready, out_valid, acc_out, act_out, sat_flag, busy
  );

  modport slave (
    input  start, vec_len, bias, in_valid, x_bits, w_bits, lane_mask, out_ready,
    output in_ready, out_valid, acc_out, act_out, sat_flag, busy
  );
endinterface

// File: rtl/bnn_acc_array.sv
// Multi-lane binarized-neuron accumulator: XNOR-popcount per beat, summed
// into a saturating signed accumulator seeded with a bias, result handed
// off through a valid/ready handshake with a sign activation.
module bnn_acc_array #(
  parameter int ACC_WIDTH = 12,
  parameter int LANES     = 4,
  parameter int LEN_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  bnn_acc_array_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [ACC_WIDTH:0]   ONE_W = {{ACC_WIDTH{1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] ONE_L = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] ZERO_L = {LEN_WIDTH{1'b0}};

  // Clamp a one-bit-wider sum into the signed accumulator range.
  function automatic logic [ACC_WIDTH-1:0] sat_fn(input logic [ACC_WIDTH:0] s);
    logic [ACC_WIDTH-1:0] r;
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
      if (s[ACC_WIDTH]) begin
        r = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        r = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else begin
      r = s[ACC_WIDTH-1:0];
    end
    return r;
  endfunction

  // True when the wide sum falls outside the accumulator range.
  function automatic logic ovf_fn(input logic [ACC_WIDTH:0] s);
    return s[ACC_WIDTH] != s[ACC_WIDTH-1];
  endfunction

  state_t               state_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [LEN_WIDTH-1:0] cnt_r;
  logic [LEN_WIDTH-1:0] vec_len_r;
  logic [ACC_WIDTH-1:0] acc_out_r;
  logic                 act_out_r;
  logic                 sat_r;
  logic                 out_valid_r;
  logic                 in_ready_r;
  logic                 busy_r;

  logic [ACC_WIDTH:0]   contrib_s;
  logic [ACC_WIDTH:0]   sum_s;
  logic [ACC_WIDTH-1:0] next_acc_s;
  logic                 clamp_s;
  logic                 accept_s;
  logic                 last_beat_s;

  // Per-beat XNOR contribution (+1 match, -1 mismatch, 0 masked) and saturating sum.
  always_comb begin
    contrib_s = {(ACC_WIDTH+1){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (bus.lane_mask[i]) begin
        if (bus.x_bits[i] ~^ bus.w_bits[i]) begin
          contrib_s = contrib_s + ONE_W;
        end else begin
          contrib_s = contrib_s - ONE_W;
        end
      end else begin
        contrib_s = contrib_s;
      end
    end
    sum_s       = {acc_r[ACC_WIDTH-1], acc_r} + contrib_s;
    next_acc_s  = sat_fn(sum_s);
    clamp_s     = ovf_fn(sum_s);
    accept_s    = bus.in_valid && in_ready_r;
    last_beat_s = (cnt_r == (vec_len_r - ONE_L));
  end

  // Control FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      acc_r       <= {ACC_WIDTH{1'b0}};
      cnt_r       <= {LEN_WIDTH{1'b0}};
      vec_len_r   <= {LEN_WIDTH{1'b0}};
      acc_out_r   <= {ACC_WIDTH{1'b0}};
      act_out_r   <= 1'b0;
      sat_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            acc_r     <= bus.bias;
            cnt_r     <= {LEN_WIDTH{1'b0}};
            vec_len_r <= bus.vec_len;
            sat_r     <= 1'b0;
            busy_r    <= 1'b1;
            if (bus.vec_len != ZERO_L) begin
              state_r    <= ST_ACCUM;
              in_ready_r <= 1'b1;
            end else begin
              // Empty vector: the bias is the result.
              state_r     <= ST_DONE;
              acc_out_r   <= bus.bias;
              act_out_r   <= ~bus.bias[ACC_WIDTH-1];
              out_valid_r <= 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (accept_s) begin
            acc_r <= next_acc_s;
            sat_r <= sat_r | clamp_s;
            if (last_beat_s) begin
              state_r     <= ST_DONE;
              acc_out_r   <= next_acc_s;
              act_out_r   <= ~next_acc_s[ACC_WIDTH-1];
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end else begin
              cnt_r <= cnt_r + ONE_L;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.acc_out   = acc_out_r;
  assign bus.act_out   = act_out_r;
  assign bus.sat_flag  = sat_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_bnn_acc_array.sv
// Directed self-checking bench for bnn_acc_array.
module tb_bnn_acc_array;

  localparam int AW = 12;
  localparam int LN = 4;
  localparam int LW = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  bnn_acc_array_if #(.ACC_WIDTH(AW), .LANES(LN), .LEN_WIDTH(LW)) bus ();

  bnn_acc_array #(.ACC_WIDTH(AW), .LANES(LN), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_neuron(input logic [LW-1:0] len, input logic [AW-1:0] b);
    bus.start   = 1'b1;
    bus.vec_len = len;
    bus.bias    = b;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic beat(input logic [LN-1:0] x, input logic [LN-1:0] w, input logic [LN-1:0] m);
    bus.in_valid  = 1'b1;
    bus.x_bits    = x;
    bus.w_bits    = w;
    bus.lane_mask = m;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.vec_len = 8'd0;
    bus.bias = 12'd0;
    bus.in_valid = 1'b0;
    bus.x_bits = 4'h0;
    bus.w_bits = 4'h0;
    bus.lane_mask = 4'hF;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chkw("rst_acc_out", bus.acc_out, 12'h000);
    rst_n = 1'b1;
    tick();

    // Basic match: 4 + 4 = 8
    start_neuron(8'd2, 12'd0);
    chk1("t1_in_ready", bus.in_ready, 1'b1);
    chk1("t1_busy", bus.busy, 1'b1);
    beat(4'hA, 4'hA, 4'hF);
    chk1("t1_no_valid_early", bus.out_valid, 1'b0);
    beat(4'h0, 4'h0, 4'hF);
    chk1("t1_out_valid", bus.out_valid, 1'b1);
    chkw("t1_acc", bus.acc_out, 12'h008);
    chk1("t1_act", bus.act_out, 1'b1);
    chk1("t1_sat", bus.sat_flag, 1'b0);
    chk1("t1_in_ready_done", bus.in_ready, 1'b0);
    release_result();
    chk1("t1_released", bus.out_valid, 1'b0);
    chk1("t1_idle_busy", bus.busy, 1'b0);

    // Mixed/negative: 1 - 2*3 = -5 (back-to-back start)
    start_neuron(8'd3, 12'd1);
    beat(4'hF, 4'h1, 4'hF);
    beat(4'hF, 4'h1, 4'hF);
    beat(4'hF, 4'h1, 4'hF);
    chk1("t2_out_valid", bus.out_valid, 1'b1);
    chkw("t2_acc", bus.acc_out, 12'hFFB);
    chk1("t2_act", bus.act_out, 1'b0);
    release_result();

    // Masking and stalls: two lanes mismatch each beat -> -4
    start_neuron(8'd2, 12'd0);
    beat(4'h0, 4'hF, 4'h3);
    tick();
    tick();
    tick();
    chk1("t3_stall_valid", bus.out_valid, 1'b0);
    chk1("t3_stall_ready", bus.in_ready, 1'b1);
    beat(4'h0, 4'hF, 4'h3);
    chk1("t3_out_valid", bus.out_valid, 1'b1);
    chkw("t3_acc", bus.acc_out, 12'hFFC);
    chk1("t3_act", bus.act_out, 1'b0);
    release_result();

    // Saturation: 2040 + 4 + 4 + 4 clamps to 2047
    start_neuron(8'd3, 12'd2040);
    beat(4'h5, 4'h5, 4'hF);
    beat(4'h5, 4'h5, 4'hF);
    beat(4'h5, 4'h5, 4'hF);
    chkw("t4_acc", bus.acc_out, 12'h7FF);
    chk1("t4_sat", bus.sat_flag, 1'b1);
    chk1("t4_act", bus.act_out, 1'b1);
    release_result();
    start_neuron(8'd1, 12'd0);
    chk1("t4b_sat_cleared", bus.sat_flag, 1'b0);
    beat(4'h3, 4'h3, 4'hF);
    chkw("t4b_acc", bus.acc_out, 12'h004);
    chk1("t4b_sat", bus.sat_flag, 1'b0);
    release_result();

    // Zero length with backpressure; start ignored while DONE
    start_neuron(8'd0, 12'hFF9);
    chk1("t5_out_valid", bus.out_valid, 1'b1);
    chkw("t5_acc", bus.acc_out, 12'hFF9);
    chk1("t5_act", bus.act_out, 1'b0);
    bus.start   = 1'b1;
    bus.vec_len = 8'd1;
    bus.bias    = 12'd5;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk1("t5_hold_valid", bus.out_valid, 1'b1);
      chkw("t5_hold_acc", bus.acc_out, 12'hFF9);
      chk1("t5_hold_act", bus.act_out, 1'b0);
      chk1("t5_hold_ready", bus.in_ready, 1'b0);
    end
    bus.start = 1'b0;
    release_result();
    chk1("t5_released", bus.out_valid, 1'b0);
    chk1("t5_idle_ready", bus.in_ready, 1'b0);
    chk1("t5_idle_busy", bus.busy, 1'b0);

    // Reset mid-operation, then a fresh neuron
    start_neuron(8'd4, 12'd0);
    beat(4'hF, 4'hF, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("t6_rst_ready", bus.in_ready, 1'b0);
    chk1("t6_rst_busy", bus.busy, 1'b0);
    chk1("t6_rst_valid", bus.out_valid, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    chk1("t6_stay_idle", bus.in_ready, 1'b0);
    start_neuron(8'd1, 12'd0);
    beat(4'hF, 4'hF, 4'hF);
    chk1("t6_out_valid", bus.out_valid, 1'b1);
    chkw("t6_acc", bus.acc_out, 12'h004);
    chk1("t6_sat", bus.sat_flag, 1'b0);
    release_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
